// File: rtl/alu_exec_pipe_if.sv
// Bundle of the instruction, result and debug buses of alu_exec_pipe.
// master = sequencer/debug host side, slave = the execute pipe.
interface alu_exec_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_wb_en;
    logic [3:0]            in_comm;
    logic                  in_mode;
    logic                  in_cin;
    logic                  in_b_sel;
    logic [DATA_WIDTH-1:0] in_imm;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_cout;
    logic                  flag_z;
    logic                  flag_n;
    logic                  flag_c;
    logic                  flag_eq;

    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_ready;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_wb_en, in_comm, in_mode, in_cin,
               in_b_sel, in_imm, res_ready, dbg_we, dbg_addr, dbg_wdata,
        input  in_ready, res_valid, res_data, res_cout, flag_z, flag_n, flag_c, flag_eq,
               dbg_rdata, dbg_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_wb_en, in_comm, in_mode, in_cin,
               in_b_sel, in_imm, res_ready, dbg_we, dbg_addr, dbg_wdata,
        output in_ready, res_valid, res_data, res_cout, flag_z, flag_n, flag_c, flag_eq,
               dbg_rdata, dbg_ready
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// One-stage execute pipe: register file + 74181-style ALU, result register with
// write-back on transfer and bypass of the pending result into the next instruction.
module alu_exec_pipe #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REGS   = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_pipe_if.slave  bus
);
    // Handshakes: a beat moves on a rising edge where valid && ready; valid never
    // depends on ready, and the result side holds res_* stable while stalled.

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
    logic                  res_cout_q,  res_cout_d;
    logic [ADDR_WIDTH-1:0] res_rd_q,    res_rd_d;
    logic                  res_wb_en_q, res_wb_en_d;
    logic                  res_eq_q,    res_eq_d;
    logic                  flag_z_q, flag_z_d;
    logic                  flag_n_q, flag_n_d;
    logic                  flag_c_q, flag_c_d;
    logic                  flag_eq_q, flag_eq_d;

    logic                  accept, transfer;
    logic                  byp_a, byp_b;
    logic [DATA_WIDTH-1:0] op_a, op_b_reg, op_b;
    logic [DATA_WIDTH-1:0] alu_f;
    logic                  alu_cout;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    assign bus.in_ready  = !res_valid_q || bus.res_ready;
    assign bus.dbg_ready = !res_valid_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign transfer      = res_valid_q && bus.res_ready;

    // An accept with a pending result always coincides with its transfer, so the
    // pending value is the one the register file is about to receive.
    assign byp_a    = res_valid_q && res_wb_en_q && (bus.in_rs1 == res_rd_q);
    assign byp_b    = res_valid_q && res_wb_en_q && (bus.in_rs2 == res_rd_q);
    assign op_a     = byp_a ? res_data_q : regs_q[bus.in_rs1];
    assign op_b_reg = byp_b ? res_data_q : regs_q[bus.in_rs2];
    assign op_b     = bus.in_b_sel ? bus.in_imm : op_b_reg;

    // Bit-level 74181: p/g are the active-high propagate/generate terms selected
    // by S; the nibble carry-lookahead chain is equivalent to this ripple.
    always_comb begin
        logic p, g, half, carry;
        alu_f = '0;
        carry = bus.in_cin;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p    = op_a[i] | (op_b[i] & bus.in_comm[0]) | (~op_b[i] & bus.in_comm[1]);
            g    = (op_a[i] & ~op_b[i] & bus.in_comm[2]) | (op_a[i] & op_b[i] & bus.in_comm[3]);
            half = p & ~g;
            alu_f[i] = bus.in_mode ? ~half : (half ^ carry);
            carry    = g | (p & carry);
        end
        alu_cout = bus.in_mode ? 1'b0 : carry;
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_rd_d    = res_rd_q;
        res_wb_en_d = res_wb_en_q;
        res_eq_d    = res_eq_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_eq_d   = flag_eq_q;
        rf_we       = 1'b0;
        rf_waddr    = bus.dbg_addr;
        rf_wdata    = bus.dbg_wdata;

        if (transfer) begin
            res_valid_d = 1'b0;
            flag_z_d    = (res_data_q == '0);
            flag_n_d    = res_data_q[DATA_WIDTH-1];
            flag_c_d    = res_cout_q;
            flag_eq_d   = res_eq_q;
        end
        if (accept) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_f;
            res_cout_d  = alu_cout;
            res_rd_d    = bus.in_rd;
            res_wb_en_d = bus.in_wb_en;
            res_eq_d    = (op_a == op_b);
        end

        // Debug writes only land while the pipe is empty, so they never race write-back.
        if (transfer && res_wb_en_q) begin
            rf_we    = 1'b1;
            rf_waddr = res_rd_q;
            rf_wdata = res_data_q;
        end else if (bus.dbg_we && !res_valid_q) begin
            rf_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_rd_q    <= '0;
            res_wb_en_q <= 1'b0;
            res_eq_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_eq_q   <= 1'b0;
        end else begin
            if (rf_we) regs_q[rf_waddr] <= rf_wdata;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_rd_q    <= res_rd_d;
            res_wb_en_q <= res_wb_en_d;
            res_eq_q    <= res_eq_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_eq_q   <= flag_eq_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_eq   = flag_eq_q;
    assign bus.dbg_rdata = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: a table of single-instruction vectors plus
// hand-written sequences for bypass, back-pressure, debug and reset corners.
module tb_alu_exec_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_exec_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    alu_exec_pipe #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  comm;
        logic        mode;
        logic        cin;
        logic        b_sel;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic [15:0] exp_data;
        logic        exp_cout;
        logic [3:0]  exp_flags;   // {z, n, c, eq}
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.in_wb_en  = 1'b0;
        bus.in_comm   = '0;
        bus.in_mode   = 1'b0;
        bus.in_cin    = 1'b0;
        bus.in_b_sel  = 1'b0;
        bus.in_imm    = '0;
        bus.res_ready = 1'b1;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    task automatic drive_instr(input logic [3:0] comm, input logic mode, input logic cin,
                               input logic b_sel, input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic [15:0] imm, input logic [2:0] rd, input logic wb_en);
        bus.in_valid = 1'b1;
        bus.in_comm  = comm;
        bus.in_mode  = mode;
        bus.in_cin   = cin;
        bus.in_b_sel = b_sel;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_rd    = rd;
        bus.in_wb_en = wb_en;
    endtask

    task automatic dbg_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = data;
        @(negedge clk);
        bus.dbg_we    = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] addr, input logic [15:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(name, bus.dbg_rdata, exp);
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        bus.res_ready = 1'b1;
        drive_instr(v.comm, v.mode, v.cin, v.b_sel, v.rs1, v.rs2, v.imm, 3'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check($sformatf("vec%0d_valid", idx), bus.res_valid, 1'b1);
        check($sformatf("vec%0d_data", idx),  bus.res_data,  v.exp_data);
        check($sformatf("vec%0d_cout", idx),  bus.res_cout,  v.exp_cout);
        @(negedge clk);
        check($sformatf("vec%0d_flags", idx),
              {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_eq}, v.exp_flags);
        check($sformatf("vec%0d_drain", idx), bus.res_valid, 1'b0);
    endtask

    initial begin
        // comm, mode, cin, b_sel, rs1, rs2, imm, exp_data, exp_cout, {z,n,c,eq}
        // r0=0000 r1=0005 r2=1234 r3=5678 r5=FFFF
        vecs[0]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 3'd2, 3'd3, 16'h0000, 16'h68AC, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0110, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3, 16'h0000, 16'hBBBC, 1'b0, 4'b0100};
        vecs[2]  = '{4'b1001, 1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 16'h0001, 16'h0000, 1'b1, 4'b1010};
        vecs[3]  = '{4'b1011, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 16'h00FF, 16'h0034, 1'b0, 4'b0000};
        vecs[4]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 16'hFF00, 16'hFF34, 1'b0, 4'b0100};
        vecs[5]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 16'h0000, 16'h444C, 1'b0, 4'b0000};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0000, 16'hEDCB, 1'b0, 4'b0100};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 16'h0000, 16'h5678, 1'b0, 4'b0000};
        vecs[8]  = '{4'b1100, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 16'h0000, 16'hFFFE, 1'b1, 4'b0110};
        vecs[9]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 16'h0000, 16'h0000, 1'b1, 4'b1010};
        vecs[10] = '{4'b1111, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0000, 16'h1233, 1'b1, 4'b0010};
        vecs[11] = '{4'b1111, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 4'b0101};
        vecs[12] = '{4'b0110, 1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 16'h0000, 16'h0000, 1'b1, 4'b1011};
        vecs[13] = '{4'b0110, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 16'h5678, 16'h0000, 1'b0, 4'b1001};
        vecs[14] = '{4'b1001, 1'b0, 1'b1, 1'b1, 3'd2, 3'd0, 16'h0000, 16'h1235, 1'b0, 4'b0000};
        vecs[15] = '{4'b1100, 1'b1, 1'b1, 1'b0, 3'd2, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 4'b0100};

        // clock/reset
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_dbg_ready", bus.dbg_ready, 1'b1);
        check("rst_res_data",  bus.res_data,  16'h0000);
        check("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_eq}, 4'b0000);
        check_reg("rst_r2", 3'd2, 16'h0000);

        dbg_write(3'd1, 16'h0005);
        dbg_write(3'd2, 16'h1234);
        dbg_write(3'd3, 16'h5678);
        dbg_write(3'd5, 16'hFFFF);
        check_reg("dbg_r2", 3'd2, 16'h1234);
        check_reg("dbg_r3", 3'd3, 16'h5678);

        for (int i = 0; i < 16; i++) apply_vec(i);

        // Dependent chain at full rate: r6 = r1 + 3, then r7 = r6 + r6 via bypass.
        @(negedge clk);
        drive_instr(4'b1001, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 16'h0003, 3'd6, 1'b1);
        @(negedge clk);
        check("chain1_valid", bus.res_valid, 1'b1);
        check("chain1_data",  bus.res_data,  16'h0008);
        check("chain1_ready", bus.in_ready,  1'b1);
        drive_instr(4'b1100, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 16'h0000, 3'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("chain2_valid", bus.res_valid, 1'b1);
        check("chain2_data",  bus.res_data,  16'h0010);
        @(negedge clk);
        check_reg("chain_r6", 3'd6, 16'h0008);
        check_reg("chain_r7", 3'd7, 16'h0010);

        // Back-pressure: r4 = r2 + 1 stalls three clocks, ignored debug write meanwhile.
        @(negedge clk);
        bus.res_ready = 1'b0;
        drive_instr(4'b1001, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 16'h0001, 3'd4, 1'b1);
        @(negedge clk);
        drive_instr(4'b1001, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 16'h0001, 3'd4, 1'b1);
        bus.dbg_we    = 1'b1;
        bus.dbg_wdata = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_in_ready", i),  bus.in_ready,  1'b0);
            check($sformatf("stall%0d_valid", i),     bus.res_valid, 1'b1);
            check($sformatf("stall%0d_data", i),      bus.res_data,  16'h1235);
            check($sformatf("stall%0d_dbg_ready", i), bus.dbg_ready, 1'b0);
            check_reg($sformatf("stall%0d_r4", i), 3'd4, 16'h0000);
            if (i < 3) @(negedge clk);
        end
        bus.dbg_we    = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("release_data", bus.res_data, 16'h1236);
        check_reg("release_r4", 3'd4, 16'h1235);
        @(negedge clk);
        check("release_drain", bus.res_valid, 1'b0);
        check_reg("final_r4", 3'd4, 16'h1236);

        // Debug write and accept in the same cycle: instruction sees the old r3.
        @(negedge clk);
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 3'd3;
        bus.dbg_wdata = 16'h0000;
        drive_instr(4'b1111, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 16'h0000, 3'd0, 1'b0);
        @(negedge clk);
        bus.dbg_we   = 1'b0;
        bus.in_valid = 1'b0;
        check("dbgacc_data", bus.res_data, 16'h5678);
        check_reg("dbgacc_r3", 3'd3, 16'h0000);

        // Reset with a pending write-back result and nonzero flags.
        apply_vec(8);
        @(negedge clk);
        bus.res_ready = 1'b0;
        drive_instr(4'b1001, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 16'h0000, 3'd7, 1'b1);
        @(negedge clk);
        check("prerst_valid", bus.res_valid, 1'b1);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        reset         = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_res_valid", bus.res_valid, 1'b0);
        check("rst2_res_data",  bus.res_data,  16'h0000);
        check("rst2_res_cout",  bus.res_cout,  1'b0);
        check("rst2_in_ready",  bus.in_ready,  1'b1);
        check("rst2_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_eq}, 4'b0000);
        check_reg("rst2_r7", 3'd7, 16'h0000);
        check_reg("rst2_r2", 3'd2, 16'h0000);
        check_reg("rst2_r5", 3'd5, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
